// File: rtl/serial_subtractor_if.sv
// ============================================================================
//  Module   : serial_subtractor_if
//  Brief    : Request/result bundle for the bit-serial subtractor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : LSB-first bit-serial a - b - bin through one full-subtractor
//             cell and a borrow flop; result valid WIDTH+1 cycles after start.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  wire                 clk,
  input  wire                 reset,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic w_a0;
  logic w_b0;
  logic w_d;
  logic w_br_next;

  // Full-subtractor cell operating on the current LSBs and the stored borrow.
  always_comb begin
    w_a0      = r_a_sr[0];
    w_b0      = r_b_sr[0];
    w_d       = w_a0 ^ w_b0 ^ r_br;
    w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_r_sr  <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_br    <= bus.bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_br   <= w_br_next;
          r_r_sr <= {w_d, r_r_sr[WIDTH-1:1]};
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_cnt  <= r_cnt + c_one;
          if (r_cnt == c_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Result is published as the FSM leaves DONE so that done and
          // the new diff/bout appear together in the following cycle.
          r_diff  <= r_r_sr;
          r_bout  <= r_br;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule

`default_nettype wire
